// File: rtl/tstate_sequencer.sv
// One-hot T-state ring sequencer for the control unit: early termination,
// stall, halt, illegal-state recovery and a completed machine-cycle counter.
module tstate_sequencer #(
  parameter int N_STATES = 6,
  parameter int IDX_W    = 4,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                en,
  input  logic                end_cyc,
  input  logic                hlt,
  output logic [N_STATES-1:0] state,
  output logic [IDX_W-1:0]    t_idx,
  output logic                wrap,
  output logic                halted,
  output logic                err,
  output logic [CNT_W-1:0]    cyc_cnt
);

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} mode_t;

  localparam logic [N_STATES-1:0] T0 = {{(N_STATES-1){1'b0}}, 1'b1};

  mode_t mode_r;

  function automatic logic is_one_hot(input logic [N_STATES-1:0] v);
    int ones;
    ones = 0;
    for (int k = 0; k < N_STATES; k++) begin
      if (v[k]) ones++;
    end
    return (ones == 1);
  endfunction

  // Control FSM plus every registered output; priority chain mirrors the
  // order in which the control unit must respond to each request.
  always_ff @(posedge clk) begin
    if (clr) begin
      mode_r  <= RUN;
      state   <= T0;
      t_idx   <= '0;
      wrap    <= 1'b0;
      halted  <= 1'b0;
      err     <= 1'b0;
      cyc_cnt <= '0;
    end else begin
      case (mode_r)
        RUN: begin
          if (!is_one_hot(state)) begin
            state <= T0;
            t_idx <= '0;
            err   <= 1'b1;
            wrap  <= 1'b1;
          end else if (hlt) begin
            mode_r <= HALTED;
            halted <= 1'b1;
            wrap   <= 1'b0;
          end else if (!en) begin
            wrap <= 1'b0;
          end else if (end_cyc || state[N_STATES-1]) begin
            // end_cyc in T0 counts as a single-T-state machine cycle
            state   <= T0;
            t_idx   <= '0;
            wrap    <= 1'b1;
            cyc_cnt <= cyc_cnt + CNT_W'(1);
          end else begin
            state <= state << 1;
            t_idx <= t_idx + IDX_W'(1);
            wrap  <= 1'b0;
          end
        end
        HALTED: begin
          wrap   <= 1'b0;
          halted <= 1'b1;
        end
        default: begin
          mode_r <= RUN;
          state  <= T0;
          t_idx  <= '0;
          wrap   <= 1'b0;
          halted <= 1'b0;
        end
      endcase
    end
  end

endmodule
